data_mem_pipe: RTL

//   Parametrised data memory for the core's load/store path, next generation of the single-cycle data memory.

---
 rtl/data_mem_pipe.sv | 176 +++++++++++++++++
 1 files changed

// File: rtl/data_mem_pipe.sv
// data_mem_pipe: byte-strobed data memory for the LSU with a zero-fill sequencer.
// Latency: READ_LATENCY cycles from the accept edge to valid_o; fully pipelined with in-order responses.
// Backpressure: ready_o is low while the array is being zero-filled, and requests are ignored then.
// Ports:
//   clk_i, rst_i             clock, asynchronous active-high reset
//   mem_req_i/ready_o        a request is accepted on an edge where both are high
//   write_enable_i           1 = write, 0 = read
//   byte_enable_i            per-byte write strobe; ignored on reads
//   addr_i, write_data_i     byte address and write data
//   clear_i                  start a zero-fill; honoured only while ready
//   valid_o, err_o           one-cycle response pulse per accepted request, with an error flag
//   read_data_o              read data; zero for writes and errors; held between responses
module data_mem_pipe #(
   parameter int          DATA_W         = 32,
   parameter int          DEPTH          = 4096,
   parameter int          READ_LATENCY   = 1,
   parameter logic [31:0] BASE_ADDR      = 32'h0,
   parameter bit          CLEAR_ON_RESET = 1'b1
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   input  logic                  mem_req_i,
   input  logic                  write_enable_i,
   input  logic [DATA_W/8-1:0]   byte_enable_i,
   input  logic [31:0]           addr_i,
   input  logic [DATA_W-1:0]     write_data_i,
   input  logic                  clear_i,
   output logic                  ready_o,
   output logic                  valid_o,
   output logic                  err_o,
   output logic [DATA_W-1:0]     read_data_o
);

   localparam int          BYTES      = DATA_W / 8;
   localparam int          AW         = $clog2(DEPTH);
   localparam int          ADDR_LSB   = $clog2(BYTES);
   localparam logic [32:0] END_ADDR   = {1'b0, BASE_ADDR} + 33'(DEPTH * BYTES);
   localparam logic [31:0] ALIGN_MASK = 32'(BYTES - 1);
   localparam logic [AW-1:0] LAST_IDX = AW'(DEPTH - 1);

   typedef enum logic {S_CLEAR, S_READY} state_t;
   localparam state_t RESET_STATE = CLEAR_ON_RESET ? S_CLEAR : S_READY;

   // ---------------------------------------------------------------
   // Fill sequencer
   // ---------------------------------------------------------------
   state_t          state_q, state_d;
   logic [AW-1:0]   cnt_q, cnt_d;
   logic            ready_q, ready_d;
   logic            fill_we;

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      fill_we = 1'b0;
      case (state_q)
         S_CLEAR: begin
            fill_we = 1'b1;
            cnt_d   = cnt_q + AW'(1);
            if (cnt_q == LAST_IDX) begin
               state_d = S_READY;
               cnt_d   = '0;
            end
         end
         S_READY: begin
            if (clear_i) begin
               state_d = S_CLEAR;
               cnt_d   = '0;
            end
         end
         default: begin
            state_d = RESET_STATE;
            cnt_d   = '0;
         end
      endcase
      // Registered copy of the next state keeps ready_o free of input-to-output paths.
      ready_d = (state_d == S_READY);
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q <= RESET_STATE;
         cnt_q   <= '0;
         ready_q <= !CLEAR_ON_RESET;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         ready_q <= ready_d;
      end
   end

   // ---------------------------------------------------------------
   // Request decode
   // ---------------------------------------------------------------
   logic            accept;
   logic            req_err;
   logic            wr_en;
   logic [AW-1:0]   idx;
   logic [DATA_W-1:0] rd_word;
   logic [DATA_W-1:0] mem_array [DEPTH];

   always_comb begin
      accept  = mem_req_i && ready_q;
      idx     = addr_i[ADDR_LSB +: AW];
      req_err = (|(addr_i & ALIGN_MASK)) ||
                (addr_i < BASE_ADDR) ||
                ({1'b0, addr_i} >= END_ADDR);
      wr_en   = accept && write_enable_i && !req_err;
      // Read happens before this edge's write lands, so a same-edge write never leaks in.
      rd_word = mem_array[idx];
   end

   // Array content is deliberately not reset; only the fill sequencer zeroes it.
   // Fill and LSU writes never coincide because requests are accepted only in S_READY.
   always_ff @(posedge clk_i) begin
      if (fill_we) begin
         mem_array[cnt_q] <= '0;
      end else if (wr_en) begin
         for (int b = 0; b < BYTES; b++) begin
            if (byte_enable_i[b]) begin
               mem_array[idx][8*b +: 8] <= write_data_i[8*b +: 8];
            end
         end
      end
   end

   // ---------------------------------------------------------------
   // Response pipeline: stage 0 captures at the accept edge, the last
   // stage drives the outputs. Error/data stages only load when a valid
   // response moves in, so the outputs hold the last response.
   // ---------------------------------------------------------------
   logic [READ_LATENCY-1:0] pv_q, pv_d;
   logic [READ_LATENCY-1:0] pe_q, pe_d;
   logic [DATA_W-1:0]       pd_q [READ_LATENCY];
   logic [DATA_W-1:0]       pd_d [READ_LATENCY];

   always_comb begin
      pv_d = '0;
      pe_d = pe_q;
      pd_d = pd_q;
      pv_d[0] = accept;
      if (accept) begin
         pe_d[0] = req_err;
         pd_d[0] = (write_enable_i || req_err) ? '0 : rd_word;
      end
      for (int i = 1; i < READ_LATENCY; i++) begin
         pv_d[i] = pv_q[i-1];
         if (pv_q[i-1]) begin
            pe_d[i] = pe_q[i-1];
            pd_d[i] = pd_q[i-1];
         end
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         pv_q <= '0;
         pe_q <= '0;
         for (int i = 0; i < READ_LATENCY; i++) begin
            pd_q[i] <= '0;
         end
      end else begin
         pv_q <= pv_d;
         pe_q <= pe_d;
         for (int i = 0; i < READ_LATENCY; i++) begin
            pd_q[i] <= pd_d[i];
         end
      end
   end

   assign ready_o     = ready_q;
   assign valid_o     = pv_q[READ_LATENCY-1];
   assign err_o       = pe_q[READ_LATENCY-1];
   assign read_data_o = pd_q[READ_LATENCY-1];

endmodule
